// File: rtl/serial_cla_subtractor_16_pkg.sv
// Shared constants and FSM encoding for the nibble-serial CLA subtractor.
// Width is fixed at NIBBLES * NIBBLE_W = 16 bits.
package serial_cla_subtractor_16_pkg;

  localparam int NIBBLES  = 4;
  localparam int NIBBLE_W = 4;
  localparam int WIDTH    = NIBBLES * NIBBLE_W;
  localparam int CNT_W    = $clog2(NIBBLES);
  localparam int NIB_SH   = $clog2(NIBBLE_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_cla_subtractor_16_cla.sv
// 4-bit carry-lookahead adder slice: s = a + b + c_in, with all carries
// formed directly from generate/propagate terms rather than rippled.
module cla_4_bit
  import serial_cla_subtractor_16_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] s,
  output logic                c_out
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign s     = p ^ c[NIBBLE_W-1:0];
  assign c_out = c[NIBBLE_W];

endmodule

// File: rtl/serial_cla_subtractor_16.sv
// 16-bit subtractor d = a - b - b_in computed as a + ~b + ~b_in, one nibble
// per cycle through a single reused CLA slice, with valid/ready handshakes.
module serial_cla_subtractor_16
  import serial_cla_subtractor_16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    nb_q, nb_d;
  logic [WIDTH-1:0]    d_q, d_d;
  logic                carry_q, carry_d;
  logic [CNT_W-1:0]    nib_q, nib_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                b_out_q, b_out_d;
  logic                ovf_q, ovf_d;

  logic [CNT_W+NIB_SH-1:0] bit_base;
  logic [NIBBLE_W-1:0]     slice_a;
  logic [NIBBLE_W-1:0]     slice_b;
  logic [NIBBLE_W-1:0]     slice_s;
  logic                    slice_c;
  logic                    accept;
  logic                    last_nib;

  assign bit_base = {nib_q, {NIB_SH{1'b0}}};
  assign slice_a  = a_q[bit_base +: NIBBLE_W];
  assign slice_b  = nb_q[bit_base +: NIBBLE_W];
  assign accept   = in_valid & in_ready_q;
  assign last_nib = (nib_q == CNT_W'(NIBBLES - 1));

  cla_4_bit u_cla (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .s     (slice_s),
    .c_out (slice_c)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    a_d         = a_q;
    nb_d        = nb_q;
    d_d         = d_q;
    carry_d     = carry_q;
    nib_d       = nib_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    b_out_d     = b_out_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d        = a;
          nb_d       = ~b;
          carry_d    = ~b_in;
          nib_d      = '0;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end

      CALC: begin
        d_d[bit_base +: NIBBLE_W] = slice_s;
        carry_d = slice_c;
        nib_d   = nib_q + 1'b1;
        if (last_nib) begin
          // Final carry of a + ~b + ~b_in is the inverted borrow; overflow
          // needs a[15], b[15] (= ~nb[15]) and the fresh top difference bit.
          b_out_d     = ~slice_c;
          ovf_d       = (a_q[WIDTH-1] ^ ~nb_q[WIDTH-1])
                      & (slice_s[NIBBLE_W-1] ^ a_q[WIDTH-1]);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      nb_q        <= '0;
      d_q         <= '0;
      carry_q     <= 1'b0;
      nib_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      b_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      nb_q        <= nb_d;
      d_q         <= d_d;
      carry_q     <= carry_d;
      nib_q       <= nib_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      b_out_q     <= b_out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign b_out     = b_out_q;
  assign ovf       = ovf_q;

endmodule
